// File: rtl/vregfile_pkg.sv
// Package for the multi-read-port vector register file.
// Holds the default geometry, the register address type for that default, and
// the clear-sequencer state encoding shared by vregfile_mp and vregfile_clr_fsm.
package vregfile_pkg;

  localparam int VREG_DATA_WIDTH = 32;
  localparam int VREG_ELEMENTS   = 8;
  localparam int VREG_VREGS      = 32;
  localparam int VREG_NREAD      = 3;
  localparam int VREG_AW         = $clog2(VREG_VREGS);
  localparam int VREG_VLEN       = VREG_DATA_WIDTH * VREG_ELEMENTS;

  typedef logic [VREG_AW-1:0] vreg_addr_t;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/vregfile_mp_if.sv
// Bus interface of the vector register file.
// Carries the read address/data bundle, the masked write port and the clear
// handshake. The master modport belongs to the decode/writeback side, the slave
// modport to vregfile_mp.
//   rd_addr_i      NREAD read addresses
//   rd_data_o      NREAD read data words (combinational from the file)
//   wr_en_i/wr_addr_i/wr_data_i/wr_elem_mask_i   element-masked write
//   wr_ready_o     writes accepted (low while a clear is running)
//   clr_req_i      request bulk clear
//   clr_busy_o     clear in progress
//   clr_done_o     one-cycle completion pulse
interface vregfile_mp_if
  import vregfile_pkg::*;
#(
  parameter int DATA_WIDTH = VREG_DATA_WIDTH,
  parameter int ELEMENTS   = VREG_ELEMENTS,
  parameter int VREGS      = VREG_VREGS,
  parameter int NREAD      = VREG_NREAD
);

  localparam int VLEN = DATA_WIDTH * ELEMENTS;
  localparam int AW   = $clog2(VREGS);

  logic [NREAD-1:0][AW-1:0]   rd_addr_i;
  logic [NREAD-1:0][VLEN-1:0] rd_data_o;
  logic                       wr_en_i;
  logic [AW-1:0]              wr_addr_i;
  logic [VLEN-1:0]            wr_data_i;
  logic [ELEMENTS-1:0]        wr_elem_mask_i;
  logic                       wr_ready_o;
  logic                       clr_req_i;
  logic                       clr_busy_o;
  logic                       clr_done_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_elem_mask_i, clr_req_i,
    input  rd_data_o, wr_ready_o, clr_busy_o, clr_done_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_elem_mask_i, clr_req_i,
    output rd_data_o, wr_ready_o, clr_busy_o, clr_done_o
  );

endinterface

// File: rtl/vregfile_clr_fsm.sv
// Clear sequencer for the vector register file.
// IDLE -> CLEAR on i_clr_req; CLEAR walks registers 1..VREGS-1, one per cycle,
// issuing a zeroing write for each; DONE emits a one-cycle pulse then returns
// to IDLE. Requests during CLEAR/DONE are ignored.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_clr_req      clear request
//   o_clr_we       zeroing write enable for the storage array
//   o_clr_addr     register being zeroed this cycle
//   o_clr_busy     sequence in progress
//   o_clr_done     one-cycle completion pulse
module vregfile_clr_fsm
  import vregfile_pkg::*;
#(
  parameter int VREGS = VREG_VREGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr_req,
  output logic                     o_clr_we,
  output logic [$clog2(VREGS)-1:0] o_clr_addr,
  output logic                     o_clr_busy,
  output logic                     o_clr_done
);

  localparam int AW = $clog2(VREGS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(VREGS - 1);

  clr_state_e    r_state;
  clr_state_e    w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLR_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLR_CLEAR;
          // Register 0 is hard-wired to zero, so the walk starts at 1.
          w_cnt_nxt   = AW'(1);
        end
      end
      CLR_CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          // Park the counter at 0 instead of letting it wrap.
          w_state_nxt = CLR_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + AW'(1);
        end
      end
      CLR_DONE: begin
        w_state_nxt = CLR_IDLE;
      end
      default: begin
        w_state_nxt = CLR_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    o_clr_we   = (r_state == CLR_CLEAR);
    o_clr_addr = r_cnt;
    o_clr_busy = (r_state == CLR_CLEAR);
    o_clr_done = (r_state == CLR_DONE);
  end

endmodule

// File: rtl/vregfile_mp.sv
// Multi-read-port vector register file with per-element write masking and a
// sequenced bulk clear.
// Register 0 always reads zero and ignores writes. Reads are combinational on
// NREAD independent ports. A write updates only the elements selected by
// wr_elem_mask_i and is accepted only while no clear is running.
// Optional feature (macro VREGFILE_BYPASS_EN): a read of the register being
// written in the same cycle returns the merged post-write value. Without it the
// new data appears on reads the following cycle.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (clears every register)
//   bus       vregfile_mp_if.slave: read ports, masked write port, clear handshake
module vregfile_mp
  import vregfile_pkg::*;
#(
  parameter int DATA_WIDTH = VREG_DATA_WIDTH,
  parameter int ELEMENTS   = VREG_ELEMENTS,
  parameter int VREGS      = VREG_VREGS,
  parameter int NREAD      = VREG_NREAD
) (
  input  logic         clk,
  input  logic         rst,
  vregfile_mp_if.slave bus
);

  localparam int VLEN = DATA_WIDTH * ELEMENTS;
  localparam int AW   = $clog2(VREGS);

  logic [VLEN-1:0] r_regs [VREGS];

  logic            w_clr_we;
  logic [AW-1:0]   w_clr_addr;
  logic            w_clr_busy;
  logic            w_clr_done;
  logic            w_wr_acc;
  logic [VLEN-1:0] w_wr_merged;

  // Expands the element mask to bit granularity and blends new over old.
  function automatic logic [VLEN-1:0] elem_merge(
    input logic [VLEN-1:0]     old_v,
    input logic [VLEN-1:0]     new_v,
    input logic [ELEMENTS-1:0] mask
  );
    logic [VLEN-1:0] bit_mask;
    for (int e = 0; e < ELEMENTS; e++) begin
      bit_mask[e*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{mask[e]}};
    end
    return (old_v & ~bit_mask) | (new_v & bit_mask);
  endfunction

  vregfile_clr_fsm #(
    .VREGS (VREGS)
  ) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_clr_req  (bus.clr_req_i),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_clr_busy (w_clr_busy),
    .o_clr_done (w_clr_done)
  );

  assign bus.wr_ready_o = !w_clr_busy;
  assign bus.clr_busy_o = w_clr_busy;
  assign bus.clr_done_o = w_clr_done;

  assign w_wr_acc    = bus.wr_en_i && !w_clr_busy && (bus.wr_addr_i != '0);
  assign w_wr_merged = elem_merge(r_regs[bus.wr_addr_i], bus.wr_data_i, bus.wr_elem_mask_i);

  // Clear writes and user writes are mutually exclusive: user writes are only
  // accepted while the sequencer is not busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_clr_we) begin
      r_regs[w_clr_addr] <= '0;
    end else if (w_wr_acc) begin
      r_regs[bus.wr_addr_i] <= w_wr_merged;
    end
  end

  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      if (bus.rd_addr_i[p] == '0) begin
        bus.rd_data_o[p] = '0;
      end else begin
        bus.rd_data_o[p] = r_regs[bus.rd_addr_i[p]];
`ifdef VREGFILE_BYPASS_EN
        if (w_wr_acc && (bus.rd_addr_i[p] == bus.wr_addr_i)) begin
          bus.rd_data_o[p] = w_wr_merged;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_vregfile_mp.sv
module tb_vregfile_mp;
  import vregfile_pkg::*;

  localparam int DW   = VREG_DATA_WIDTH;
  localparam int NE   = VREG_ELEMENTS;
  localparam int NV   = VREG_VREGS;
  localparam int NR   = VREG_NREAD;
  localparam int VL   = VREG_VLEN;
  localparam int AW   = VREG_AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vregfile_mp_if bus ();

  vregfile_mp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: register contents plus clear progress.
  logic [VL-1:0] mem [NV];
  int            clr_next;   // 0: not clearing; else next register the clear zeroes
  bit            done_m;

  logic          s_busy, s_done, s_ready;
  logic [VL-1:0] s_rd [NR];

  task automatic check(input string tag, input logic [VL-1:0] got, input logic [VL-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) mem[i] = '0;
    clr_next = 0;
    done_m   = 1'b0;
  endtask

  function automatic logic [VL-1:0] apply_mask(input logic [VL-1:0] old_v,
                                               input logic [VL-1:0] new_v,
                                               input logic [NE-1:0] m);
    logic [VL-1:0] r = old_v;
    for (int e = 0; e < NE; e++)
      if (m[e]) r[e*DW +: DW] = new_v[e*DW +: DW];
    return r;
  endfunction

  function automatic logic [VL-1:0] rand_vec();
    logic [VL-1:0] v;
    for (int e = 0; e < NE; e++) v[e*DW +: DW] = $urandom;
    return v;
  endfunction

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // then advance the model across the rising edge. Entered and left at negedge.
  task automatic cycle(input bit we, input int wa, input logic [VL-1:0] wd,
                       input logic [NE-1:0] wm, input bit cr,
                       input int ra0, input int ra1, input int ra2);
    int            ra [NR];
    bit            busy_m, acc;
    logic [VL-1:0] exp_v;
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    bus.wr_en_i        = we;
    bus.wr_addr_i      = AW'(wa);
    bus.wr_data_i      = wd;
    bus.wr_elem_mask_i = wm;
    bus.clr_req_i      = cr;
    for (int p = 0; p < NR; p++) bus.rd_addr_i[p] = AW'(ra[p]);
    #1;
    busy_m = (clr_next != 0);
    acc    = we && !busy_m && (wa != 0);
    s_busy  = bus.clr_busy_o;
    s_done  = bus.clr_done_o;
    s_ready = bus.wr_ready_o;
    check("clr_busy", VL'(s_busy), VL'(busy_m));
    check("clr_done", VL'(s_done), VL'(done_m));
    check("wr_ready", VL'(s_ready), VL'(!busy_m));
    for (int p = 0; p < NR; p++) begin
      exp_v = (ra[p] == 0) ? '0 : mem[ra[p]];
`ifdef VREGFILE_BYPASS_EN
      if (acc && ra[p] == wa) exp_v = apply_mask(mem[ra[p]], wd, wm);
`endif
      s_rd[p] = bus.rd_data_o[p];
      check($sformatf("rd_port%0d_addr%0d", p, ra[p]), s_rd[p], exp_v);
    end
    @(posedge clk);
    if (busy_m) begin
      mem[clr_next] = '0;
      clr_next++;
      if (clr_next == NV) begin
        clr_next = 0;
        done_m   = 1'b1;
      end
    end else if (done_m) begin
      done_m = 1'b0;
    end else if (cr) begin
      clr_next = 1;
    end
    if (acc) mem[wa] = apply_mask(mem[wa], wd, wm);
    @(negedge clk);
  endtask

  task automatic idle_read(input int a0, input int a1, input int a2);
    cycle(1'b0, 0, '0, '0, 1'b0, a0, a1, a2);
  endtask

  logic [VL-1:0] v_old, v_new, v_exp;
  int            busy_cnt, done_cnt;

  initial begin
    rst = 1'b1;
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.wr_elem_mask_i = '0; bus.clr_req_i = 1'b0; bus.rd_addr_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",  VL'(bus.clr_busy_o), '0);
    check("rst_done",  VL'(bus.clr_done_o), '0);
    check("rst_ready", VL'(bus.wr_ready_o), VL'(1));
    @(negedge clk);
    rst = 1'b0;

    // Register 0 is immutable
    cycle(1'b1, 0, {NE{32'hDEADBEEF}}, 8'hFF, 1'b0, 0, 0, 0);
    idle_read(0, 0, 0);
    for (int p = 0; p < NR; p++) check("reg0_zero", s_rd[p], '0);

    // Partial-mask overwrite of reg5
    cycle(1'b1, 5, {NE{32'h11111111}}, 8'hFF, 1'b0, 5, 0, 0);
    cycle(1'b1, 5, {NE{32'hFFFFFFFF}}, 8'h0F, 1'b0, 5, 0, 0);
    idle_read(5, 0, 0);
    check("reg5_partial", s_rd[0], {{4{32'h11111111}}, {4{32'hFFFFFFFF}}});

    // Independent ports
    v_new = rand_vec();
    cycle(1'b1, 9, v_new, 8'hFF, 1'b0, 0, 0, 0);
    idle_read(5, 5, 9);
    check("port2_reg9", s_rd[2], v_new);
    check("port1_reg5", s_rd[1], {{4{32'h11111111}}, {4{32'hFFFFFFFF}}});

    // Fill and bulk clear with a write attempt mid-clear
    for (int r = 1; r < NV; r++)
      cycle(1'b1, r, rand_vec() | {{(VL-1){1'b0}}, 1'b1}, 8'hFF, 1'b0, r, r - 1, 0);
    cycle(1'b0, 0, '0, '0, 1'b1, 1, 2, 3);
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 34; k++) begin
      cycle(k == 10, 3, {NE{32'hA5A5A5A5}}, 8'hFF, k == 5,
            int'($urandom_range(0, NV - 1)), int'($urandom_range(0, NV - 1)), 3);
      busy_cnt += int'(s_busy);
      done_cnt += int'(s_done);
    end
    check("clr_busy_cycles", VL'(busy_cnt), VL'(NV - 1));
    check("clr_done_pulses", VL'(done_cnt), VL'(1));
    for (int r = 0; r < NV; r += 3) begin
      idle_read(r, (r + 1) % NV, (r + 2) % NV);
      check("after_clear", s_rd[0] | s_rd[1] | s_rd[2], '0);
    end

    // Reset in the middle of a clear
    for (int r = 1; r < 8; r++) cycle(1'b1, r, rand_vec(), 8'hFF, 1'b0, r, 0, 0);
    cycle(1'b0, 0, '0, '0, 1'b1, 0, 0, 0);
    for (int k = 0; k < 9; k++) idle_read(20, 21, 22);
    rst = 1'b1;
    #1;
    check("midclr_rst_busy",  VL'(bus.clr_busy_o), '0);
    check("midclr_rst_ready", VL'(bus.wr_ready_o), VL'(1));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_read(1, 5, 7);
    check("midclr_rst_regs", s_rd[0] | s_rd[1] | s_rd[2], '0);
    v_new = rand_vec();
    cycle(1'b1, 4, v_new, 8'hFF, 1'b0, 0, 0, 0);
    idle_read(4, 0, 0);
    check("write_after_rst", s_rd[0], v_new);

    // Same-cycle write/read of reg7
    v_old = rand_vec();
    v_new = rand_vec();
    cycle(1'b1, 7, v_old, 8'hFF, 1'b0, 0, 0, 0);
    cycle(1'b1, 7, v_new, 8'h3C, 1'b0, 7, 0, 0);
    v_exp = apply_mask(v_old, v_new, 8'h3C);
`ifdef VREGFILE_BYPASS_EN
    check("same_cycle_bypass", s_rd[0], v_exp);
`else
    check("same_cycle_old", s_rd[0], v_old);
`endif
    idle_read(7, 0, 0);
    check("next_cycle_new", s_rd[0], v_exp);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, NV - 1)), rand_vec(),
            NE'($urandom), ($urandom_range(0, 59) == 0),
            int'($urandom_range(0, NV - 1)), int'($urandom_range(0, NV - 1)),
            int'($urandom_range(0, NV - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
